// File: rtl/axi4lite_slave_ctrl_pkg.sv
// Response encodings and FSM state type shared by the AXI4-Lite slave front-end.
// The memory response codes are translated onto AXI BRESP/RRESP by the controller.
package axi4lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] MEM_OKAY  = 2'b00;
    localparam logic [1:0] MEM_RO    = 2'b01;
    localparam logic [1:0] MEM_RANGE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_WR_DONE,
        ST_B_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RD_DONE,
        ST_R_RESP
    } state_t;

    // A read-only word is a slave error; an out-of-range word is a decode error.
    // The unused 2'b10 code is treated conservatively as a slave error.
    function automatic logic [1:0] wr_resp_map(input logic [1:0] mem_resp);
        case (mem_resp)
            MEM_RO:    return SLVERR;
            MEM_RANGE: return DECERR;
            default:   return SLVERR;
        endcase
    endfunction

endpackage

// File: rtl/axi4lite_slave_ctrl_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) between a master and this slave.
// Clock and reset are deliberately kept outside the bundle.
interface axi4lite_slave_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);

    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;

    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;

    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;

    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;

    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axi4lite_slave_ctrl.sv
// AXI4-Lite slave front-end for the 64-word memory: latches AW/W/AR, serialises one
// transaction at a time onto the memory WEN/REN port and maps memory codes to BRESP/RRESP.
module axi4lite_slave_ctrl
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 6,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    axi4lite_slave_ctrl_if.slave      s_axi,

    output logic                      M_WEN,
    output logic                      M_REN,
    output logic [MEM_ADDR_WIDTH-1:0] M_AWADDR,
    output logic [MEM_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [STRB_WIDTH-1:0]     M_WSTRB,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    input  logic [1:0]                M_WRESP,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_WDONE,
    input  logic                      M_RDONE,
    input  logic [DATA_WIDTH-1:0]     M_RDATA
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    // Channel hold registers
    logic                  aw_held_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic                  w_held_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] wstrb_reg;
    logic                  ar_held_reg;
    logic [ADDR_WIDTH-1:0] araddr_reg;

    // FSM state and registered response payloads
    state_t                state_reg, state_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  prefer_rd_reg, prefer_rd_next;

    logic                      aw_ready, w_ready, ar_ready;
    logic                      wr_clr, rd_clr;
    logic                      wr_pend;
    logic                      aw_bad, ar_bad;
    logic [MEM_ADDR_WIDTH-1:0] aw_idx, ar_idx;

    assign aw_ready = !aw_held_reg && !reset;
    assign w_ready  = !w_held_reg  && !reset;
    assign ar_ready = !ar_held_reg && !reset;

    assign wr_pend = aw_held_reg && w_held_reg;
    assign aw_idx  = awaddr_reg[MEM_ADDR_WIDTH+1:2];
    assign ar_idx  = araddr_reg[MEM_ADDR_WIDTH+1:2];

    // Address bits above the word index must be zero, otherwise the memory is never touched.
    assign aw_bad = |(awaddr_reg >> (MEM_ADDR_WIDTH + 2));
    assign ar_bad = |(araddr_reg >> (MEM_ADDR_WIDTH + 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_reg <= 1'b0;
            awaddr_reg  <= '0;
            w_held_reg  <= 1'b0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            ar_held_reg <= 1'b0;
            araddr_reg  <= '0;
        end else begin
            if (wr_clr) begin
                aw_held_reg <= 1'b0;
            end else if (s_axi.AWVALID && aw_ready) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_axi.AWADDR;
            end

            if (wr_clr) begin
                w_held_reg <= 1'b0;
            end else if (s_axi.WVALID && w_ready) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi.WDATA;
                wstrb_reg  <= s_axi.WSTRB;
            end

            if (rd_clr) begin
                ar_held_reg <= 1'b0;
            end else if (s_axi.ARVALID && ar_ready) begin
                ar_held_reg <= 1'b1;
                araddr_reg  <= s_axi.ARADDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bresp_reg     <= OKAY;
            rresp_reg     <= OKAY;
            rdata_reg     <= '0;
            cnt_reg       <= '0;
            prefer_rd_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bresp_reg     <= bresp_next;
            rresp_reg     <= rresp_next;
            rdata_reg     <= rdata_next;
            cnt_reg       <= cnt_next;
            prefer_rd_reg <= prefer_rd_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bresp_next     = bresp_reg;
        rresp_next     = rresp_reg;
        rdata_next     = rdata_reg;
        cnt_next       = '0;
        prefer_rd_next = prefer_rd_reg;
        wr_clr         = 1'b0;
        rd_clr         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The priority flag only flips when write and read actually contend.
                if (wr_pend && (!ar_held_reg || !prefer_rd_reg)) begin
                    if (ar_held_reg) begin
                        prefer_rd_next = 1'b1;
                    end
                    if (aw_bad) begin
                        bresp_next = DECERR;
                        state_next = ST_B_RESP;
                    end else begin
                        state_next = ST_WR_REQ;
                    end
                end else if (ar_held_reg) begin
                    if (wr_pend) begin
                        prefer_rd_next = 1'b0;
                    end
                    if (ar_bad) begin
                        rresp_next = DECERR;
                        rdata_next = '0;
                        state_next = ST_R_RESP;
                    end else begin
                        state_next = ST_RD_REQ;
                    end
                end
            end

            ST_WR_REQ: state_next = ST_WR_RESP;

            ST_WR_RESP: begin
                if (M_WRESP == MEM_OKAY) begin
                    state_next = ST_WR_DONE;
                end else begin
                    bresp_next = wr_resp_map(M_WRESP);
                    state_next = ST_B_RESP;
                end
            end

            ST_WR_DONE: begin
                if (M_WDONE) begin
                    bresp_next = OKAY;
                    state_next = ST_B_RESP;
                end else if (cnt_reg == TMO_LAST) begin
                    bresp_next = SLVERR;
                    state_next = ST_B_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_B_RESP: begin
                if (s_axi.BREADY) begin
                    wr_clr     = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            ST_RD_REQ: state_next = ST_RD_RESP;

            ST_RD_RESP: begin
                if (M_RRESP == MEM_OKAY) begin
                    state_next = ST_RD_DONE;
                end else begin
                    rresp_next = DECERR;
                    rdata_next = '0;
                    state_next = ST_R_RESP;
                end
            end

            ST_RD_DONE: begin
                if (M_RDONE) begin
                    rresp_next = OKAY;
                    rdata_next = M_RDATA;
                    state_next = ST_R_RESP;
                end else if (cnt_reg == TMO_LAST) begin
                    rresp_next = SLVERR;
                    rdata_next = '0;
                    state_next = ST_R_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_R_RESP: begin
                if (s_axi.RREADY) begin
                    rd_clr     = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Memory request port; the read decode in the memory qualifies on M_AWADDR,
    // so reads drive the index onto both address buses.
    always_comb begin
        M_WEN    = 1'b0;
        M_REN    = 1'b0;
        M_AWADDR = '0;
        M_ARADDR = '0;
        M_WSTRB  = '0;
        M_WDATA  = '0;
        case (state_reg)
            ST_WR_REQ, ST_WR_RESP: begin
                M_WEN    = 1'b1;
                M_AWADDR = aw_idx;
                M_WSTRB  = wstrb_reg;
                M_WDATA  = wdata_reg;
            end
            ST_RD_REQ, ST_RD_RESP: begin
                M_REN    = 1'b1;
                M_AWADDR = ar_idx;
                M_ARADDR = ar_idx;
            end
            default: ;
        endcase
    end

    assign s_axi.AWREADY = aw_ready;
    assign s_axi.WREADY  = w_ready;
    assign s_axi.ARREADY = ar_ready;
    assign s_axi.BVALID  = (state_reg == ST_B_RESP);
    assign s_axi.BRESP   = bresp_reg;
    assign s_axi.RVALID  = (state_reg == ST_R_RESP);
    assign s_axi.RRESP   = rresp_reg;
    assign s_axi.RDATA   = rdata_reg;

endmodule

// File: tb/tb_axi4lite_slave_ctrl.sv
// Directed bench for axi4lite_slave_ctrl with a small behavioural memory behind it.
// Words 0-3 are read-only (word 1 holds 9), words 60-63 are out of range.
`timescale 1ns/1ps
module tb_axi4lite_slave_ctrl;
    import axi4lite_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int MW  = 6;
    localparam int SW  = 4;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi4lite_slave_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    logic          m_wen, m_ren;
    logic [MW-1:0] m_awaddr, m_araddr;
    logic [SW-1:0] m_wstrb;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_wresp, m_rresp;
    logic          m_wdone = 1'b0;
    logic          m_rdone = 1'b0;

    axi4lite_slave_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .STRB_WIDTH(SW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .s_axi(bus),
        .M_WEN(m_wen), .M_REN(m_ren), .M_AWADDR(m_awaddr), .M_ARADDR(m_araddr),
        .M_WSTRB(m_wstrb), .M_WDATA(m_wdata), .M_WRESP(m_wresp), .M_RRESP(m_rresp),
        .M_WDONE(m_wdone), .M_RDONE(m_rdone), .M_RDATA(m_rdata)
    );

    // Behavioural memory: acts in the second cycle of a request, completion pulse follows.
    logic [DW-1:0] mem [64];
    logic          mem_stall = 1'b0;
    logic          wen_d = 1'b0;
    logic          ren_d = 1'b0;

    function automatic logic [1:0] mem_class(input logic [MW-1:0] idx, input logic is_wr);
        if (idx >= 6'd60) return 2'b11;
        if (is_wr && idx < 6'd4) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    assign m_wresp = m_wen ? mem_class(m_awaddr, 1'b1) : 2'b00;
    assign m_rresp = m_ren ? mem_class(m_awaddr, 1'b0) : 2'b00;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 1) ? 32'd9 : 32'd0;
            wen_d   <= 1'b0;
            ren_d   <= 1'b0;
            m_wdone <= 1'b0;
            m_rdone <= 1'b0;
        end else begin
            wen_d   <= m_wen;
            ren_d   <= m_ren;
            m_wdone <= 1'b0;
            m_rdone <= 1'b0;
            if (m_wen && wen_d && m_wresp == 2'b00) begin
                mem[m_awaddr] <= merge(mem[m_awaddr], m_wdata, m_wstrb);
                m_wdone       <= !mem_stall;
            end
            if (m_ren && ren_d && m_rresp == 2'b00 && !mem_stall) begin
                m_rdata <= mem[m_araddr];
                m_rdone <= 1'b1;
            end
        end
    end

    int overlap_cnt = 0;
    always @(negedge clk) if (m_wen && m_ren) overlap_cnt++;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for BVALID or RVALID; lat counts negedges after the request edge.
    task automatic wait_resp(output int lat, output int en_cyc,
                             output logic [MW-1:0] cap_aw, output logic [MW-1:0] cap_ar);
        lat = 0; en_cyc = 0; cap_aw = '0; cap_ar = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (m_wen || m_ren) begin
                en_cyc++;
                cap_aw = m_awaddr;
                cap_ar = m_araddr;
            end
            if (bus.BVALID || bus.RVALID) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic issue_aw_w(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb);
        @(negedge clk);
        bus.AWVALID = 1'b1; bus.AWADDR = addr;
        bus.WVALID  = 1'b1; bus.WDATA  = data; bus.WSTRB = strb;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    endtask

    task automatic issue_ar(input logic [AW-1:0] addr);
        @(negedge clk);
        bus.ARVALID = 1'b1; bus.ARADDR = addr;
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [1:0] exp_resp, input int exp_lat);
        int lat, en;
        logic [MW-1:0] ca, cr;
        issue_aw_w(addr, data, strb);
        wait_resp(lat, en, ca, cr);
        check_eq({tag, " b_latency"}, lat, exp_lat);
        check_eq({tag, " wen_cycles"}, en, 2);
        check_eq({tag, " m_awaddr"}, 32'(ca), 32'(addr[MW+1:2]));
        check_eq({tag, " bvalid"}, 32'(bus.BVALID), 1);
        check_eq({tag, " bresp"}, 32'(bus.BRESP), 32'(exp_resp));
        @(posedge clk); #1;
        check_eq({tag, " bvalid_drop"}, 32'(bus.BVALID), 0);
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                           input logic [1:0] exp_resp, input int exp_lat);
        int lat, en;
        logic [MW-1:0] ca, cr;
        issue_ar(addr);
        wait_resp(lat, en, ca, cr);
        check_eq({tag, " r_latency"}, lat, exp_lat);
        check_eq({tag, " ren_cycles"}, en, 2);
        check_eq({tag, " m_awaddr"}, 32'(ca), 32'(addr[MW+1:2]));
        check_eq({tag, " m_araddr"}, 32'(cr), 32'(addr[MW+1:2]));
        check_eq({tag, " rvalid"}, 32'(bus.RVALID), 1);
        check_eq({tag, " rresp"}, 32'(bus.RRESP), 32'(exp_resp));
        check_eq({tag, " rdata"}, bus.RDATA, exp_data);
        @(posedge clk); #1;
        check_eq({tag, " rvalid_drop"}, 32'(bus.RVALID), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, en, bad;
        logic [MW-1:0] ca, cr;

        bus.AWVALID = 1'b0; bus.AWADDR = '0;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB = '0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0;
        bus.BREADY  = 1'b1; bus.RREADY = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst awready", 32'(bus.AWREADY), 0);
        check_eq("rst bvalid", 32'(bus.BVALID), 0);
        check_eq("rst rvalid", 32'(bus.RVALID), 0);
        check_eq("rst m_wen", 32'(m_wen), 0);
        check_eq("rst rdata", bus.RDATA, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst awready", 32'(bus.AWREADY), 1);
        check_eq("post_rst wready", 32'(bus.WREADY), 1);
        check_eq("post_rst arready", 32'(bus.ARREADY), 1);

        // Basic OKAY / error paths
        do_write("wr_w10", 8'h28, 32'hDEADBEEF, 4'hF, OKAY, 5);
        do_read ("rd_w10", 8'h28, 32'hDEADBEEF, OKAY, 5);
        do_write("wr_ro1", 8'h04, 32'h12345678, 4'hF, SLVERR, 4);
        do_read ("rd_ro1", 8'h04, 32'd9, OKAY, 5);
        do_read ("rd_w63", 8'hFC, 32'h0, DECERR, 4);
        do_write("wr_w63", 8'hFC, 32'hCAFEF00D, 4'hF, DECERR, 4);
        do_write("wr_strb", 8'h28, 32'h00AA0000, 4'h4, OKAY, 5);
        do_read ("rd_strb", 8'h28, 32'hDEAABEEF, OKAY, 5);

        // Completion timeouts
        mem_stall = 1'b1;
        do_write("wr_tmo", 8'h50, 32'h11111111, 4'hF, SLVERR, 4 + TMO);
        do_read ("rd_tmo", 8'h28, 32'h0, SLVERR, 4 + TMO);
        mem_stall = 1'b0;

        // Contest 1: W three cycles ahead of AW, AR arrives with AW -> write wins
        @(negedge clk);
        bus.WVALID = 1'b1; bus.WDATA = 32'hA5A55A5A; bus.WSTRB = 4'hF;
        @(posedge clk); #1;
        bus.WVALID = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("c1 wready_held", 32'(bus.WREADY), 0);
        bus.AWVALID = 1'b1; bus.AWADDR = 8'h30;
        bus.ARVALID = 1'b1; bus.ARADDR = 8'h28;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        wait_resp(lat, en, ca, cr);
        check_eq("c1 b_first", 32'(bus.BVALID), 1);
        check_eq("c1 r_not_first", 32'(bus.RVALID), 0);
        check_eq("c1 b_latency", lat, 5);
        check_eq("c1 bresp", 32'(bus.BRESP), 32'(OKAY));
        @(posedge clk); #1;
        wait_resp(lat, en, ca, cr);
        check_eq("c1 r_latency", lat, 5);
        check_eq("c1 rdata", bus.RDATA, 32'hDEAABEEF);
        @(posedge clk); #1;

        // Contest 2: all three together -> read wins this time
        @(negedge clk);
        bus.AWVALID = 1'b1; bus.AWADDR = 8'h34;
        bus.WVALID  = 1'b1; bus.WDATA  = 32'h0F0F0F0F; bus.WSTRB = 4'hF;
        bus.ARVALID = 1'b1; bus.ARADDR = 8'h30;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        wait_resp(lat, en, ca, cr);
        check_eq("c2 r_first", 32'(bus.RVALID), 1);
        check_eq("c2 b_not_first", 32'(bus.BVALID), 0);
        check_eq("c2 rdata", bus.RDATA, 32'hA5A55A5A);
        @(posedge clk); #1;
        wait_resp(lat, en, ca, cr);
        check_eq("c2 b_latency", lat, 5);
        check_eq("c2 bresp", 32'(bus.BRESP), 32'(OKAY));
        @(posedge clk); #1;
        do_read("rd_c2", 8'h34, 32'h0F0F0F0F, OKAY, 5);

        // BREADY held low for 5 cycles on an error response
        bus.BREADY = 1'b0;
        issue_aw_w(8'h08, 32'h77, 4'hF);
        wait_resp(lat, en, ca, cr);
        check_eq("stall b_latency", lat, 4);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.BVALID !== 1'b1 || bus.BRESP !== SLVERR || bus.AWREADY !== 1'b0) bad++;
        end
        check_eq("stall held_cycles_bad", bad, 0);
        check_eq("stall bresp", 32'(bus.BRESP), 32'(SLVERR));
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        check_eq("stall bvalid_drop", 32'(bus.BVALID), 0);
        check_eq("stall awready_back", 32'(bus.AWREADY), 1);

        // Reset while waiting in WR_DONE
        mem_stall = 1'b1;
        issue_aw_w(8'h3C, 32'h55, 4'hF);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst awready", 32'(bus.AWREADY), 0);
        check_eq("midrst bvalid", 32'(bus.BVALID), 0);
        check_eq("midrst bresp", 32'(bus.BRESP), 0);
        check_eq("midrst rdata", bus.RDATA, 0);
        check_eq("midrst m_wen", 32'(m_wen), 0);
        check_eq("midrst m_awaddr", 32'(m_awaddr), 0);
        @(negedge clk);
        reset = 1'b0;
        mem_stall = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst awready_after", 32'(bus.AWREADY), 1);
        check_eq("midrst wready_after", 32'(bus.WREADY), 1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.BVALID !== 1'b0 || m_wen !== 1'b0) bad++;
        end
        check_eq("midrst dropped", bad, 0);
        do_write("wr_after_rst", 8'h3C, 32'h12345678, 4'hF, OKAY, 5);
        do_read ("rd_after_rst", 8'h3C, 32'h12345678, OKAY, 5);

        check_eq("wen_ren_exclusive", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
